// File: rtl/div_16_pkg.sv
// Shared types and constants for the sequential 16-bit restoring divider.
// DIV_16_SIGNED_EN adds the two's-complement sign-handling states.
package div_16_pkg;
    localparam int DIV_WIDTH = 16;
    localparam int DIV_ITER  = 16;
    localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOTIENT = 16'hFFFF;

`ifdef DIV_16_SIGNED_EN
    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_DONE, S_NEG_A, S_NEG_B, S_FIX_Q, S_FIX_R
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_CALC, S_DONE
    } state_t;
`endif
endpackage

// File: rtl/sub_16.sv
// 16-bit ripple-borrow subtractor: diff = in0 - in1 - bin, bout set on underflow.
module sub_16
    import div_16_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] in0,
    input  logic [DIV_WIDTH-1:0] in1,
    input  logic                 bin,
    output logic [DIV_WIDTH-1:0] diff,
    output logic                 bout
);
    always_comb begin
        logic v_b;
        v_b  = bin;
        diff = '0;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            diff[i] = in0[i] ^ in1[i] ^ v_b;
            v_b     = (~in0[i] & in1[i]) | (~(in0[i] ^ in1[i]) & v_b);
        end
        bout = v_b;
    end
endmodule

// File: rtl/div_16_seq.sv
// Multi-cycle 16-bit restoring divider, one trial subtraction per clock through a single sub_16.
// Define DIV_16_SIGNED_EN for two's-complement operands (magnitude/fix-up states share the subtractor).
module div_16_seq
    import div_16_pkg::*;
#(
    parameter int                   WIDTH       = 16,
    parameter logic [WIDTH-1:0]     DZ_QUOTIENT = DIV_DZ_QUOTIENT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    if (WIDTH != DIV_WIDTH) begin : g_bad_width
        $error("div_16_seq: WIDTH must be 16");
    end

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_q, r_pr;
    logic             r_dz;
    logic             r_done, r_dzo;
    logic [WIDTH-1:0] r_quot, r_rem;
`ifdef DIV_16_SIGNED_EN
    logic             r_sa, r_sb;
`endif

    logic [WIDTH:0]   w_pr_sh;
    logic [WIDTH-1:0] w_in0, w_in1, w_diff;
    logic             w_bout, w_fits, w_accept;

    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_accept    = start && !busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dzo;

    assign w_pr_sh = {r_pr, r_a[r_cnt]};
    // A set bit 16 means the shifted partial remainder already exceeds any divisor.
    assign w_fits  = w_pr_sh[WIDTH] | ~w_bout;

`ifdef DIV_16_SIGNED_EN
    always_comb begin
        w_in0 = '0;
        w_in1 = r_b;
        case (r_state)
            S_CALC:  w_in0 = w_pr_sh[WIDTH-1:0];
            S_NEG_A: w_in1 = r_a;
            S_FIX_Q: w_in1 = r_q;
            S_FIX_R: w_in1 = r_pr;
            default: ;
        endcase
    end
`else
    assign w_in0 = w_pr_sh[WIDTH-1:0];
    assign w_in1 = r_b;
`endif

    sub_16 u_sub (
        .in0  (w_in0),
        .in1  (w_in1),
        .bin  (1'b0),
        .diff (w_diff),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_pr    <= '0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dzo   <= 1'b0;
`ifdef DIV_16_SIGNED_EN
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            // Results become visible only when leaving DONE, so outputs never show partial work.
            if (r_state == S_DONE) begin
                r_done <= 1'b1;
                r_quot <= r_q;
                r_rem  <= r_pr;
                r_dzo  <= r_dz;
            end
            if (w_accept) begin
                r_a   <= dividend;
                r_b   <= divisor;
                r_cnt <= 4'(DIV_ITER - 1);
`ifdef DIV_16_SIGNED_EN
                r_sa  <= dividend[WIDTH-1];
                r_sb  <= divisor[WIDTH-1];
`endif
                if (divisor == '0) begin
                    r_q     <= DZ_QUOTIENT;
                    r_pr    <= dividend;
                    r_dz    <= 1'b1;
                    r_state <= S_DONE;
                end else begin
                    r_q     <= '0;
                    r_pr    <= '0;
                    r_dz    <= 1'b0;
`ifdef DIV_16_SIGNED_EN
                    r_state <= S_NEG_A;
`else
                    r_state <= S_CALC;
`endif
                end
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_CALC: begin
                        r_pr       <= w_fits ? w_diff : w_pr_sh[WIDTH-1:0];
                        r_q[r_cnt] <= w_fits;
                        r_cnt      <= r_cnt - 4'd1;
                        if (r_cnt == '0) begin
`ifdef DIV_16_SIGNED_EN
                            r_state <= S_FIX_Q;
`else
                            r_state <= S_DONE;
`endif
                        end
                    end
                    S_DONE: r_state <= S_IDLE;
`ifdef DIV_16_SIGNED_EN
                    S_NEG_A: begin
                        if (r_sa) r_a <= w_diff;
                        r_state <= S_NEG_B;
                    end
                    S_NEG_B: begin
                        if (r_sb) r_b <= w_diff;
                        r_state <= S_CALC;
                    end
                    S_FIX_Q: begin
                        if (r_sa ^ r_sb) r_q <= w_diff;
                        r_state <= S_FIX_R;
                    end
                    S_FIX_R: begin
                        if (r_sa) r_pr <= w_diff;
                        r_state <= S_DONE;
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_16_seq.sv
// Self-checking bench for div_16_seq: vector table driven through a scoreboard, plus
// busy-ignore, back-to-back and mid-operation reset sequences.
module tb_div_16_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0, divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

`ifdef DIV_16_SIGNED_EN
    localparam int LAT = 21;
`else
    localparam int LAT = 17;
`endif

    typedef struct {
        logic [15:0] a, b, q, r;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [15:0] q, r;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;
    int   ndone = 0;

    div_16_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every done pulse pops one expectation.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        if (done === 1'b1) begin
            ndone++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.dz);
                chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic push(input logic [15:0] q, r, input logic dz, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.acc = cyc + 1; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_op(input vec_t v);
        @(negedge clk);
        dividend = v.a;
        divisor  = v.b;
        start    = 1'b1;
        push(v.q, v.r, v.dz, (v.b == 16'h0) ? 1 : LAT);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, (v.b != 16'h0));
        wait_idle();
    endtask

    vec_t tbl[$];
    vec_t v;
    int   nd;

    initial begin
        tbl.push_back('{16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0});
        tbl.push_back('{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0});
        tbl.push_back('{16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0});
        tbl.push_back('{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1});
        tbl.push_back('{16'h0064, 16'h000A, 16'h000A, 16'h0000, 1'b0});
        tbl.push_back('{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0});
`ifdef DIV_16_SIGNED_EN
        tbl.push_back('{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0});
        tbl.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0});
        tbl.push_back('{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0});
        tbl.push_back('{16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0});
`else
        tbl.push_back('{16'h8000, 16'h0003, 16'h2AAA, 16'h0002, 1'b0});
        tbl.push_back('{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0});
        tbl.push_back('{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0});
`endif

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) do_op(tbl[i]);

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        dividend = 16'h0064; divisor = 16'h000A; start = 1'b1;
        push(16'h000A, 16'h0000, 1'b0, LAT);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_mid_op", busy, 1);
        dividend = 16'h1111; divisor = 16'h0002; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        // Start held in DONE launches the next operation back-to-back.
        @(negedge clk);
        dividend = 16'h03E8; divisor = 16'h0007; start = 1'b1;
        push(16'h008E, 16'h0006, 1'b0, LAT);
        @(negedge clk);
        start = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        chk("busy_in_done", busy, 0);
        chk("done_before_pulse", done, 0);
        dividend = 16'hFFFF; divisor = 16'h0001; start = 1'b1;
        push(16'hFFFF, 16'h0000, 1'b0, LAT);
        @(negedge clk);
        start = 1'b0;
        chk("busy_second_op", busy, 1);
        wait_idle();

        // Asynchronous reset during CALC aborts with no done pulse.
        @(negedge clk);
        dividend = 16'h03E8; divisor = 16'h0007; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT - 9) @(negedge clk);
        chk("busy_before_abort", busy, 1);
        nd = ndone;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 8) @(negedge clk);
        chk("no_done_after_abort", ndone, nd);

        // Divider still usable after the abort.
        v = '{16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0};
        do_op(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
